led_counter_ctrl: RTL and testbench

//  Parametrised successor to the fixed 4-bit LED counter top. Divides the 50 MHz system clock

---
 rtl/led_counter_ctrl_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/led_counter_ctrl.sv | 94 +++++++++
 tb/tb_led_counter_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/led_counter_ctrl_pkg.sv
// Shared constants for the LED counter block: LED display mode encodings
// and the board clock frequency used to derive the default tick rate.
package led_counter_ctrl_pkg;

  // Board system clock, Hz. One tick per second when PRESCALE equals this.
  localparam int unsigned SYS_CLK_HZ = 50_000_000;

  // LED display modes as seen on the led_mode pins.
  typedef enum logic [1:0] {
    LED_MODE_BIN    = 2'b00,
    LED_MODE_ONEHOT = 2'b01,
    LED_MODE_THERM  = 2'b10,
    LED_MODE_INV    = 2'b11
  } led_mode_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock divider. While en is high it counts 0..PRESCALE-1 and
// asserts tick for the single cycle spent at PRESCALE-1, wrapping to 0 on
// the following edge. While en is low the count is frozen and tick is low.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PRE_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] cnt;

  // Tick is decoded from the current count so the consumer acts on the
  // edge that closes the terminal cycle.
  assign tick = en && (cnt == LAST);

  // Divider count: advance while enabled, wrap at the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_counter_ctrl.sv
// Modulo-N up/down counter advanced by a prescaled tick, with a synchronous
// saturating load and a combinational LED decode in four display modes.
module led_counter_ctrl
  import led_counter_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned MODULO   = 16,
  parameter int unsigned PRESCALE = SYS_CLK_HZ,
  parameter int unsigned LED_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [1:0]       led_mode,
  output logic [CNT_W-1:0] count_out,
  output logic             wrap,
  output logic [LED_W-1:0] led_out
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IDX_W = (LED_W > 1) ? $clog2(LED_W) : 1;

  // Compare loads one bit wider so MODULO == 2**CNT_W stays representable.
  localparam logic [CNT_W:0]   MOD_EXT = (CNT_W + 1)'(MODULO);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULO - 1);

  logic tick;

  tick_prescaler #(
    .PRESCALE (PRESCALE),
    .PRE_W    (PRE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // Counter and wrap flag: load beats tick; wrap only pulses on a modulo
  // rollover in either direction and clears on every other edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_out <= '0;
      wrap      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        count_out <= ({1'b0, load_val} >= MOD_EXT) ? MAX_CNT : load_val;
      end else if (tick) begin
        if (dir) begin
          if (count_out == MAX_CNT) begin
            count_out <= '0;
            wrap      <= 1'b1;
          end else begin
            count_out <= count_out + 1'b1;
          end
        end else begin
          if (count_out == '0) begin
            count_out <= MAX_CNT;
            wrap      <= 1'b1;
          end else begin
            count_out <= count_out - 1'b1;
          end
        end
      end
    end
  end

  logic [IDX_W-1:0] idx;
  logic [LED_W-1:0] bin_val;
  logic [LED_W:0]   therm_ext;

  // Position of the lit LED for the runner/thermometer modes.
  assign idx       = IDX_W'(32'(count_out) % LED_W);
  assign bin_val   = LED_W'(count_out);
  assign therm_ext = (LED_W + 1)'(2) << idx;

  // LED decode from the registered count; follows led_mode immediately.
  always_comb begin
    // NOTE: default first so no mode path leaves led_out unassigned (no latch).
    led_out = bin_val;
    case (led_mode)
      LED_MODE_BIN:    led_out = bin_val;
      LED_MODE_ONEHOT: led_out = LED_W'(1) << idx;
      LED_MODE_THERM:  led_out = LED_W'(therm_ext - (LED_W + 1)'(1));
      LED_MODE_INV:    led_out = ~bin_val;
      default:         led_out = bin_val;
    endcase
  end

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl with PRESCALE=4, MODULO=10, CNT_W=4,
// LED_W=4. Inputs change and outputs are sampled on the falling clock edge.
module tb_led_counter_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [1:0] led_mode;
  logic [3:0] count_out;
  logic       wrap;
  logic [3:0] led_out;

  int n_cmp;
  int n_bad;
  int wrap_seen;

  led_counter_ctrl #(
    .CNT_W    (4),
    .MODULO   (10),
    .PRESCALE (4),
    .LED_W    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .led_mode  (led_mode),
    .count_out (count_out),
    .wrap      (wrap),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lv;
    logic [1:0] mode;
    logic [3:0] exp_cnt;
    logic [3:0] exp_led;
  } led_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full clock: rising edge then settle to the falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  led_vec_t vecs[12];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    wrap_seen = 0;

    vecs[0]  = '{4'd6,  2'b00, 4'd6, 4'b0110};
    vecs[1]  = '{4'd6,  2'b01, 4'd6, 4'b0100};
    vecs[2]  = '{4'd6,  2'b10, 4'd6, 4'b0111};
    vecs[3]  = '{4'd6,  2'b11, 4'd6, 4'b1001};
    vecs[4]  = '{4'd9,  2'b01, 4'd9, 4'b0010};
    vecs[5]  = '{4'd9,  2'b10, 4'd9, 4'b0011};
    vecs[6]  = '{4'd15, 2'b00, 4'd9, 4'b1001};
    vecs[7]  = '{4'd10, 2'b11, 4'd9, 4'b0110};
    vecs[8]  = '{4'd0,  2'b10, 4'd0, 4'b0001};
    vecs[9]  = '{4'd0,  2'b11, 4'd0, 4'b1111};
    vecs[10] = '{4'd7,  2'b01, 4'd7, 4'b1000};
    vecs[11] = '{4'd3,  2'b10, 4'd3, 4'b1111};

    rst_n    = 1'b0;
    en       = 1'b0;
    dir      = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    led_mode = 2'b00;
    cyc(2);
    check("reset_count", count_out, 0);
    check("reset_wrap", wrap, 0);
    check("reset_led_bin", led_out, 4'b0000);
    led_mode = 2'b11;
    #1;
    check("reset_led_inv", led_out, 4'b1111);
    led_mode = 2'b00;

    // Test 1: free count up, tick every 4th clock, one wrap at edge 40.
    rst_n = 1'b1;
    en    = 1'b1;
    dir   = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      cyc(1);
      check("up_count", count_out, (k / 4) % 10);
      check("up_wrap", wrap, (k == 40) ? 1 : 0);
      if (wrap) wrap_seen++;
    end
    check("up_wrap_once", wrap_seen, 1);

    // Test 2: count is 1 with the prescaler at 0; step down through 0 to 9.
    dir = 1'b0;
    cyc(4);
    check("down_to0_count", count_out, 0);
    check("down_to0_wrap", wrap, 0);
    cyc(3);
    check("down_hold0", count_out, 0);
    cyc(1);
    check("down_wrap_count", count_out, 9);
    check("down_wrap_flag", wrap, 1);
    cyc(1);
    check("down_wrap_clear", wrap, 0);
    cyc(3);
    check("down_8_count", count_out, 8);
    check("down_8_wrap", wrap, 0);

    // Test 3: saturating load, then a load coinciding with a tick.
    load     = 1'b1;
    load_val = 4'd12;
    cyc(1);
    load = 1'b0;
    check("load_clamp_count", count_out, 9);
    check("load_clamp_wrap", wrap, 0);
    cyc(2);
    load     = 1'b1;
    load_val = 4'd5;
    cyc(1);
    load = 1'b0;
    check("load_vs_tick_count", count_out, 5);
    check("load_vs_tick_wrap", wrap, 0);
    cyc(3);
    check("post_load_hold", count_out, 5);
    cyc(1);
    check("post_load_tick", count_out, 4);

    // Test 4: freeze at 3 with two prescale cycles still to go.
    dir      = 1'b1;
    load     = 1'b1;
    load_val = 4'd3;
    cyc(1);
    load = 1'b0;
    cyc(1);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      check("freeze_count", count_out, 3);
      check("freeze_wrap", wrap, 0);
    end
    en = 1'b1;
    cyc(1);
    check("resume_hold", count_out, 3);
    cyc(1);
    check("resume_tick", count_out, 4);
    en = 1'b0;

    // Test 5: LED decode table with en low so only loads move the count.
    for (int i = 0; i < 12; i++) begin
      load     = 1'b1;
      load_val = vecs[i].lv;
      led_mode = vecs[i].mode;
      cyc(1);
      load = 1'b0;
      check($sformatf("vec%0d_count", i), count_out, vecs[i].exp_cnt);
      check($sformatf("vec%0d_led", i), led_out, vecs[i].exp_led);
      check($sformatf("vec%0d_wrap", i), wrap, 0);
    end
    led_mode = 2'b00;

    // Test 6: asynchronous reset mid-count at 7, then a full prescale interval.
    en       = 1'b1;
    load     = 1'b1;
    load_val = 4'd7;
    cyc(1);
    load = 1'b0;
    cyc(1);
    check("pre_reset_count", count_out, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_count", count_out, 0);
    check("async_reset_wrap", wrap, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    check("post_reset_hold", count_out, 0);
    cyc(1);
    check("post_reset_tick", count_out, 1);
    check("post_reset_wrap", wrap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
